local_port_eject_receiver: RTL

LOCAL_PORT_EJECT_RECEIVER -- requirements
Module: local_port_eject_receiver

---
 rtl/rvh_noc_pkg.sv | 15 +
 rtl/local_eject_vc_fifo.sv | 54 +++++
 rtl/local_port_eject_receiver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rvh_noc_pkg.sv
// Shared NoC definitions: node coordinate widths, device port width and the
// io_port_t destination record carried by flits.
package rvh_noc_pkg;

    localparam int NodeID_X_Width           = 4;
    localparam int NodeID_Y_Width           = 4;
    localparam int NodeID_Device_Port_Width = 2;

    typedef struct packed {
        logic [NodeID_X_Width-1:0]           x_id;
        logic [NodeID_Y_Width-1:0]           y_id;
        logic [NodeID_Device_Port_Width-1:0] device_port;
    } io_port_t;

endpackage

// File: rtl/local_eject_vc_fifo.sv
// Single-VC ejection buffer: DEPTH-entry FIFO with wrap-bit pointers so full
// and empty are told apart without a separate counter.
module local_eject_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full is judged on the start-of-cycle pointers, so a same-cycle pop
    // never makes room for a write into a full buffer.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    assign wr_ptr_d  = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/local_port_eject_receiver.sv
// Local ejection receiver: buffers flits per VC, returns credits, and serves
// the device round-robin. Optional LOCAL_EJECT_DEVICE_PORT_CHECK_EN adds a device-port match.
module local_port_eject_receiver
    import rvh_noc_pkg::*;
#(
    parameter  int VC_NUM         = 2,
    parameter  int VC_DEPTH       = 4,
    parameter  int PAYLOAD_W      = 64,
    parameter  int DEVICE_PORT_ID = 0,
    localparam int VC_W           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NodeID_X_Width-1:0]           node_id_x_i,
    input  logic [NodeID_Y_Width-1:0]           node_id_y_i,
    input  logic                                flit_vld_i,
    input  logic [VC_W-1:0]                     flit_vc_id_i,
    input  logic [NodeID_X_Width-1:0]           flit_tgt_x_i,
    input  logic [NodeID_Y_Width-1:0]           flit_tgt_y_i,
    input  logic [NodeID_Device_Port_Width-1:0] flit_tgt_port_i,
    input  logic [PAYLOAD_W-1:0]                flit_payload_i,
    output logic [VC_NUM-1:0]                   credit_vld_o,
    output logic                                dev_vld_o,
    input  logic                                dev_rdy_i,
    output logic [VC_W-1:0]                     dev_vc_id_o,
    output logic [PAYLOAD_W-1:0]                dev_payload_o,
    output logic                                err_dest_mismatch_o,
    output logic                                err_overflow_o
);

    localparam logic [NodeID_Device_Port_Width-1:0] PORT_ID =
        DEVICE_PORT_ID[NodeID_Device_Port_Width-1:0];

    io_port_t             flit_tgt;
    logic                 xy_match;
    logic                 dest_match;
    logic [VC_NUM-1:0]    vc_sel;
    logic [VC_NUM-1:0]    wr_en;
    logic [VC_NUM-1:0]    rd_en;
    logic [VC_NUM-1:0]    empty;
    logic [VC_NUM-1:0]    full;
    logic [VC_NUM-1:0]    mismatch;
    logic                 overflow_hit;
    logic [PAYLOAD_W-1:0] head [VC_NUM];

    logic                 grant_vld;
    logic [VC_W-1:0]      grant_vc;
    logic                 handshake;
    int                   rr_idx;

    logic [VC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    logic [VC_W-1:0]      lock_vc_q, lock_vc_d;
    logic [VC_NUM-1:0]    credit_q, credit_d;
    logic                 err_mm_q, err_mm_d;
    logic                 err_ov_q, err_ov_d;

    assign flit_tgt = {flit_tgt_x_i, flit_tgt_y_i, flit_tgt_port_i};
    assign xy_match = (flit_tgt.x_id == node_id_x_i) && (flit_tgt.y_id == node_id_y_i);

`ifdef LOCAL_EJECT_DEVICE_PORT_CHECK_EN
    assign dest_match = xy_match && (flit_tgt.device_port == PORT_ID);
`else
    logic port_check_unused;
    assign port_check_unused = (flit_tgt.device_port == PORT_ID);
    assign dest_match        = xy_match;
`endif

    always_comb begin
        vc_sel = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_sel[v] = (flit_vc_id_i == VC_W'(v));
        end
    end

    // A mismatching flit never occupies a slot, so its credit goes straight back.
    assign wr_en        = {VC_NUM{flit_vld_i && dest_match}} & vc_sel & ~full;
    assign mismatch     = {VC_NUM{flit_vld_i && !dest_match}} & vc_sel;
    assign overflow_hit = flit_vld_i && dest_match && |(vc_sel & full);

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        local_eject_vc_fifo #(
            .DEPTH (VC_DEPTH),
            .WIDTH (PAYLOAD_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (flit_payload_i),
            .rd_en_i   (rd_en[g]),
            .rd_data_o (head[g]),
            .empty_o   (empty[g]),
            .full_o    (full[g])
        );
    end

    // Round-robin search from rr_ptr_q; a stalled offer stays locked so the
    // device sees a stable VC and payload until it accepts.
    always_comb begin
        grant_vld = 1'b0;
        grant_vc  = '0;
        rr_idx    = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            rr_idx = (int'(rr_ptr_q) + i) % VC_NUM;
            if (!grant_vld && !empty[rr_idx[VC_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_vc  = rr_idx[VC_W-1:0];
            end
        end
        if (lock_q) begin
            grant_vld = 1'b1;
            grant_vc  = lock_vc_q;
        end
    end

    assign handshake = grant_vld && dev_rdy_i;

    always_comb begin
        rd_en = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            rd_en[v] = handshake && (grant_vc == VC_W'(v));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (grant_vc == VC_W'(VC_NUM - 1)) ? '0 : grant_vc + VC_W'(1);
        end
        lock_d    = grant_vld && !dev_rdy_i;
        lock_vc_d = grant_vc;
        credit_d  = rd_en | mismatch;
        err_mm_d  = err_mm_q | (|mismatch);
        err_ov_d  = err_ov_q | overflow_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            credit_q  <= '0;
            err_mm_q  <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
            credit_q  <= credit_d;
            err_mm_q  <= err_mm_d;
            err_ov_q  <= err_ov_d;
        end
    end

    assign credit_vld_o        = credit_q;
    assign dev_vld_o           = grant_vld;
    assign dev_vc_id_o         = grant_vld ? grant_vc : '0;
    assign dev_payload_o       = grant_vld ? head[grant_vc] : '0;
    assign err_dest_mismatch_o = err_mm_q;
    assign err_overflow_o      = err_ov_q;

endmodule
